ex_mem_stage: RTL and testbench



---
 rtl/ex_pkg.sv | 23 ++
 rtl/mul_iter.sv | 69 ++++++
 rtl/ex_mem_stage.sv | 112 +++++++++++
 tb/tb_ex_mem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply FSM states
// and the control values that make up a pipeline bubble.
package ex_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_NOR   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  localparam logic [1:0] WB_BUBBLE  = 2'b00;
  localparam logic [2:0] MEM_BUBBLE = 3'b000;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Exposes its FSM state so the stage can derive stall and writeback timing.
module mul_iter
  import ex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output mul_state_t        state,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  mul_state_t        state_next;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && !abort) state_next = S_BUSY;
      S_BUSY: begin
        if (abort)                 state_next = S_IDLE;
        else if (cnt == LAST_STEP) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Only the low DATA_W bits of the product are kept, so the shifted
  // multiplicand may simply drop its upper bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_IDLE && start && !abort) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_BUSY && !abort) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign product = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage with the EX/MEM pipeline register; MULT is delegated
// to mul_iter and stalls the front of the pipe while it iterates.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic              clkEXMEM,
  input  logic              rstEXMEM,
  input  logic [1:0]        Wb1,
  input  logic [2:0]        Mem1,
  input  logic              RegDst,
  input  logic [2:0]        ALUOp,
  input  logic              ALUSrc,
  input  logic [DATA_W-1:0] tAdd,
  input  logic [DATA_W-1:0] tALU,
  input  logic [DATA_W-1:0] tMux32,
  input  logic [DATA_W-1:0] tACsl,
  input  logic [4:0]        tMux5_1,
  input  logic [4:0]        tMux5_2,
  input  logic              jump_out,
  input  logic              flush,
  output logic [1:0]        Wb2,
  output logic [2:0]        Mem2,
  output logic [DATA_W-1:0] BrTarget,
  output logic              Zero,
  output logic [DATA_W-1:0] ALURes,
  output logic [DATA_W-1:0] WrData,
  output logic [4:0]        WrReg,
  output logic              jump2,
  output logic              stall
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] stage_res;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] product;
  logic [4:0]        wr_reg;
  logic              mul_start;
  mul_state_t        mul_state;

  assign b_op      = ALUSrc ? tACsl : tMux32;
  assign wr_reg    = RegDst ? tMux5_2 : tMux5_1;
  assign br_target = tAdd + {tACsl[DATA_W-3:0], 2'b00};

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      ALU_ADD:   alu_res = tALU + b_op;
      ALU_SUB:   alu_res = tALU - b_op;
      ALU_AND:   alu_res = tALU & b_op;
      ALU_OR:    alu_res = tALU | b_op;
      ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(tALU) < $signed(b_op))};
      ALU_NOR:   alu_res = ~(tALU | b_op);
      ALU_PASSB: alu_res = b_op;
      default:   alu_res = '0;
    endcase
  end

  assign mul_start = (mul_state == S_IDLE) && (ALUOp == ALU_MUL) && !flush;
  assign stall     = !rstEXMEM && (mul_start || mul_state == S_BUSY);
  assign stage_res = (mul_state == S_DONE) ? product : alu_res;

  mul_iter #(
    .DATA_W   (DATA_W),
    .MUL_STEPS(MUL_STEPS)
  ) u_mul (
    .clk    (clkEXMEM),
    .rst    (rstEXMEM),
    .start  (mul_start),
    .abort  (flush),
    .a      (tALU),
    .b      (b_op),
    .state  (mul_state),
    .product(product)
  );

  // While a multiply is starting or iterating, downstream sees only bubbles.
  always_ff @(posedge clkEXMEM or posedge rstEXMEM) begin
    if (rstEXMEM) begin
      Wb2      <= '0;
      Mem2     <= '0;
      BrTarget <= '0;
      Zero     <= 1'b0;
      ALURes   <= '0;
      WrData   <= '0;
      WrReg    <= '0;
      jump2    <= 1'b0;
    end else if (flush || mul_start || mul_state == S_BUSY) begin
      Wb2      <= WB_BUBBLE;
      Mem2     <= MEM_BUBBLE;
      BrTarget <= '0;
      Zero     <= 1'b0;
      ALURes   <= '0;
      WrData   <= '0;
      WrReg    <= '0;
      jump2    <= 1'b0;
    end else begin
      Wb2      <= Wb1;
      Mem2     <= Mem1;
      BrTarget <= br_target;
      Zero     <= (stage_res == '0);
      ALURes   <= stage_res;
      WrData   <= tMux32;
      WrReg    <= wr_reg;
      jump2    <= jump_out;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected EX/MEM contents are queued when
// an instruction is presented and checked when the register loads it.
module tb_ex_mem_stage;

  logic        clkEXMEM = 1'b0;
  logic        rstEXMEM = 1'b0;
  logic [1:0]  Wb1 = '0;
  logic [2:0]  Mem1 = '0;
  logic        RegDst = 1'b0;
  logic [2:0]  ALUOp = '0;
  logic        ALUSrc = 1'b0;
  logic [31:0] tAdd = '0, tALU = '0, tMux32 = '0, tACsl = '0;
  logic [4:0]  tMux5_1 = '0, tMux5_2 = '0;
  logic        jump_out = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  Wb2;
  logic [2:0]  Mem2;
  logic [31:0] BrTarget, ALURes, WrData;
  logic        Zero, jump2, stall;
  logic [4:0]  WrReg;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] br;
    logic        zero;
    logic [31:0] res;
    logic [31:0] wrdata;
    logic [4:0]  wrreg;
    logic        jump;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failures = 0;

  ex_mem_stage dut (
    .clkEXMEM(clkEXMEM), .rstEXMEM(rstEXMEM), .Wb1(Wb1), .Mem1(Mem1),
    .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .tAdd(tAdd),
    .tALU(tALU), .tMux32(tMux32), .tACsl(tACsl), .tMux5_1(tMux5_1),
    .tMux5_2(tMux5_2), .jump_out(jump_out), .flush(flush), .Wb2(Wb2),
    .Mem2(Mem2), .BrTarget(BrTarget), .Zero(Zero), .ALURes(ALURes),
    .WrData(WrData), .WrReg(WrReg), .jump2(jump2), .stall(stall)
  );

  always #5 clkEXMEM = ~clkEXMEM;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic exp_t modelExpect();
    exp_t        e;
    logic [31:0] b;
    e = '0;
    if (flush) return e;
    b = ALUSrc ? tACsl : tMux32;
    case (ALUOp)
      3'b000: e.res = tALU + b;
      3'b001: e.res = tALU - b;
      3'b010: e.res = tALU & b;
      3'b011: e.res = tALU | b;
      3'b100: e.res = ($signed(tALU) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: e.res = ~(tALU | b);
      3'b110: e.res = tALU * b;
      default: e.res = b;
    endcase
    e.zero   = (e.res == 32'd0);
    e.wb     = Wb1;
    e.mem    = Mem1;
    e.br     = tAdd + (tACsl << 2);
    e.wrdata = tMux32;
    e.wrreg  = RegDst ? tMux5_2 : tMux5_1;
    e.jump   = jump_out;
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic src, input logic dst,
                               input logic [1:0] wb, input logic [2:0] mem, input logic jmp,
                               input logic [31:0] pc4, input logic [31:0] a, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [4:0] f1, input logic [4:0] f2,
                               input logic fl, input bit push);
    ALUOp = op; ALUSrc = src; RegDst = dst; Wb1 = wb; Mem1 = mem; jump_out = jmp;
    tAdd = pc4; tALU = a; tMux32 = rt; tACsl = imm; tMux5_1 = f1; tMux5_2 = f2;
    flush = fl;
    if (push) exp_q.push_back(modelExpect());
  endtask

  task automatic compareHead(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, ".Wb2"},      32'(Wb2),   32'(e.wb));
    checkOutput({tag, ".Mem2"},     32'(Mem2),  32'(e.mem));
    checkOutput({tag, ".BrTarget"}, BrTarget,   e.br);
    checkOutput({tag, ".Zero"},     32'(Zero),  32'(e.zero));
    checkOutput({tag, ".ALURes"},   ALURes,     e.res);
    checkOutput({tag, ".WrData"},   WrData,     e.wrdata);
    checkOutput({tag, ".WrReg"},    32'(WrReg), 32'(e.wrreg));
    checkOutput({tag, ".jump2"},    32'(jump2), 32'(e.jump));
  endtask

  task automatic runSingle(input string tag);
    @(negedge clkEXMEM);
    compareHead(tag);
  endtask

  // Counts stall cycles, checks bubbles while stalled, then the DONE writeback.
  task automatic runMult(input string tag);
    int  cycles = 0;
    bit  ended = 0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (!stall) begin
        ended = 1;
        break;
      end
      cycles++;
      @(negedge clkEXMEM);
      #1;
      if (Wb2 !== 2'b00 || Mem2 !== 3'b000 || jump2 !== 1'b0)
        checkOutput({tag, ".bubble"}, {27'd0, jump2, Wb2, Mem2}, 32'd0);
    end
    checkOutput({tag, ".stall_end"}, 32'(ended), 32'd1);
    checkOutput({tag, ".stall_cycles"}, cycles, 32'd33);
    @(negedge clkEXMEM);
    compareHead(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ctl"},   {24'd0, jump2, Zero, Wb2, Mem2, 1'b0}, 32'd0);
    checkOutput({tag, ".res"},   ALURes,   32'd0);
    checkOutput({tag, ".br"},    BrTarget, 32'd0);
    checkOutput({tag, ".wd"},    WrData,   32'd0);
    checkOutput({tag, ".wr"},    32'(WrReg), 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #1 rstEXMEM = 1'b1;
    repeat (2) @(negedge clkEXMEM);
    checkAllZero("reset");
    rstEXMEM = 1'b0;

    applyStimulus(3'b000, 1, 0, 2'b11, 3'b000, 0, 32'h100, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd9, 5'd3, 0, 1);
    runSingle("add");
    checkOutput("add.lit", ALURes, 32'd2);
    checkOutput("add.wrreg_lit", 32'(WrReg), 32'd9);

    applyStimulus(3'b001, 0, 1, 2'b10, 3'b001, 0, 32'h200, 32'd7, 32'd7, 32'd4, 5'd1, 5'd17, 0, 1);
    runSingle("sub");
    checkOutput("sub.zero_lit", 32'(Zero), 32'd1);

    applyStimulus(3'b100, 0, 0, 2'b01, 3'b100, 1, 32'h0040_0004, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 5'd4, 5'd5, 0, 1);
    runSingle("slt_br");
    checkOutput("br.lit", BrTarget, 32'h0040_0000);
    checkOutput("slt.lit", ALURes, 32'd1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 6));
      if (op == 3'b110) op = 3'b111;
      applyStimulus(op, 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 0, 1);
      runSingle($sformatf("rand%0d", i));
    end

    applyStimulus(3'b000, 0, 1, 2'b11, 3'b111, 1, 32'h40, 32'd3, 32'd4, 32'd1, 5'd2, 5'd6, 1, 1);
    runSingle("flush_alu");

    applyStimulus(3'b110, 0, 1, 2'b11, 3'b010, 0, 32'h300, 32'd7, 32'd6, 32'd0, 5'd8, 5'd12, 0, 1);
    runMult("mul7x6");
    checkOutput("mul7x6.lit", ALURes, 32'd42);

    applyStimulus(3'b110, 1, 0, 2'b10, 3'b000, 0, 32'h304, 32'hFFFF_FFFD, 32'd99, 32'd5, 5'd11, 5'd13, 0, 1);
    runMult("mul_neg");
    checkOutput("mul_neg.lit", ALURes, 32'hFFFF_FFF1);

    applyStimulus(3'b110, 0, 0, 2'b01, 3'b001, 1, 32'h308, 32'h1234_5678, 32'd0, 32'd0, 5'd14, 5'd15, 0, 1);
    runMult("mul_zero");
    checkOutput("mul_zero.zlit", 32'(Zero), 32'd1);

    applyStimulus(3'b110, 0, 0, 2'b11, 3'b011, 0, 32'h400, 32'd9, 32'd9, 32'd0, 5'd3, 5'd4, 0, 0);
    repeat (10) @(negedge clkEXMEM);
    applyStimulus(3'b110, 0, 0, 2'b11, 3'b011, 0, 32'h400, 32'd9, 32'd9, 32'd0, 5'd3, 5'd4, 1, 1);
    runSingle("flush_busy");
    applyStimulus(3'b011, 0, 0, 2'b10, 3'b000, 0, 32'h404, 32'hF0, 32'h0F, 32'd0, 5'd20, 5'd21, 0, 1);
    #1 checkOutput("flush_busy.idle_stall", 32'(stall), 32'd0);
    runSingle("after_flush");

    applyStimulus(3'b110, 0, 0, 2'b11, 3'b111, 1, 32'h500, 32'd3, 32'd3, 32'd0, 5'd7, 5'd8, 0, 0);
    repeat (5) @(negedge clkEXMEM);
    #2 rstEXMEM = 1'b1;
    #1 checkAllZero("reset_mid");
    @(negedge clkEXMEM);
    rstEXMEM = 1'b0;
    applyStimulus(3'b000, 0, 0, 2'b11, 3'b100, 0, 32'h600, 32'd10, 32'd20, 32'd0, 5'd30, 5'd31, 0, 1);
    #1 checkOutput("post_reset.stall", 32'(stall), 32'd0);
    runSingle("post_reset_add");

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
